// File: rtl/axi_4_lite_regfile_slv_pkg.sv
// Shared AXI4-Lite response codes and helpers for the register-file slave.
package axi_4_lite_regfile_slv_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_EXOKAY = 2'b01,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_e;

    localparam int unsigned AXI_PROT_W    = 3;
    localparam int unsigned AXI_RESP_W    = 2;
    localparam int unsigned BYTE_W        = 8;

    // Access outcome to response code: only OKAY or SLVERR are ever produced.
    function automatic axi_resp_e resp_of(input logic ok);
        return ok ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi_4_lite_strb_merge.sv
// Combinational byte-lane merge: lanes with strb=1 take new data, others keep old.
module axi_4_lite_strb_merge
    import axi_4_lite_regfile_slv_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]        old_data,
    input  logic [DATA_W-1:0]        new_data,
    input  logic [DATA_W/BYTE_W-1:0] strb,
    output logic [DATA_W-1:0]        merged_c
);

    localparam int unsigned STRB_W = DATA_W / BYTE_W;

    always_comb begin
        merged_c = old_data;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            if (strb[b]) begin
                merged_c[b*BYTE_W +: BYTE_W] = new_data[b*BYTE_W +: BYTE_W];
            end
        end
    end

endmodule

// File: rtl/axi_4_lite_regfile_slv.sv
// AXI4-Lite slave register file with read-only hardware-backed words and per-word write strobes.
// AW and W are captured independently; one write response outstanding at a time.
module axi_4_lite_regfile_slv
    import axi_4_lite_regfile_slv_pkg::*;
#(
    parameter int unsigned C_AXI_DATA_WIDTH   = 32,
    parameter int unsigned C_AXI_ADDR_WIDTH   = 8,
    parameter int unsigned C_REGISTERS_NUMBER = 16,
    parameter logic [C_REGISTERS_NUMBER-1:0] C_RO_MASK = '0
) (
    input  logic                                         S_AXI_ACLK,
    input  logic                                         S_AXI_ARESETN,
    input  logic                                         S_AXI_AWVALID,
    output logic                                         S_AXI_AWREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]                  S_AXI_AWADDR,
    input  logic [AXI_PROT_W-1:0]                        S_AXI_AWPROT,
    input  logic                                         S_AXI_WVALID,
    output logic                                         S_AXI_WREADY,
    input  logic [C_AXI_DATA_WIDTH-1:0]                  S_AXI_WDATA,
    input  logic [C_AXI_DATA_WIDTH/8-1:0]                S_AXI_WSTRB,
    output logic                                         S_AXI_BVALID,
    input  logic                                         S_AXI_BREADY,
    output logic [AXI_RESP_W-1:0]                        S_AXI_BRESP,
    input  logic                                         S_AXI_ARVALID,
    output logic                                         S_AXI_ARREADY,
    input  logic [C_AXI_ADDR_WIDTH-1:0]                  S_AXI_ARADDR,
    input  logic [AXI_PROT_W-1:0]                        S_AXI_ARPROT,
    output logic                                         S_AXI_RVALID,
    input  logic                                         S_AXI_RREADY,
    output logic [C_AXI_DATA_WIDTH-1:0]                  S_AXI_RDATA,
    output logic [AXI_RESP_W-1:0]                        S_AXI_RRESP,
    output logic [C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH-1:0] REG_OUT,
    input  logic [C_REGISTERS_NUMBER*C_AXI_DATA_WIDTH-1:0] RO_IN,
    output logic [C_REGISTERS_NUMBER-1:0]                WR_PULSE
);

    localparam int unsigned DATA_W   = C_AXI_DATA_WIDTH;
    localparam int unsigned STRB_W   = DATA_W / BYTE_W;
    localparam int unsigned ADDR_LSB = $clog2(STRB_W);
    localparam int unsigned IDX_W    = C_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam int unsigned N        = C_REGISTERS_NUMBER;

    // Write-path state
    logic              aw_held_q, w_held_q;
    logic              awready_q, wready_q;
    logic [IDX_W-1:0]  aw_idx_q;
    logic [DATA_W-1:0] w_data_q;
    logic [STRB_W-1:0] w_strb_q;
    logic              bvalid_q;
    axi_resp_e         bresp_q;
    logic [N-1:0]      wr_pulse_q;
    logic [DATA_W-1:0] regs_q [N];

    // Read-path state
    logic              arready_q, rvalid_q;
    logic [DATA_W-1:0] rdata_q;
    axi_resp_e         rresp_q;

    logic              aw_hs_c, w_hs_c, ar_hs_c, commit_c;
    logic              aw_held_d, w_held_d, rvalid_d;
    logic [N-1:0]      wr_hit_c, wr_en_c;
    logic              wr_ok_c;
    logic [DATA_W-1:0] wr_old_c, wr_merged_c;
    logic [IDX_W-1:0]  ar_idx_c;
    logic              rd_ok_c;
    logic [DATA_W-1:0] rd_data_c;

    assign aw_hs_c  = S_AXI_AWVALID && awready_q;
    assign w_hs_c   = S_AXI_WVALID && wready_q;
    assign ar_hs_c  = S_AXI_ARVALID && arready_q;
    assign commit_c = aw_held_q && w_held_q && !bvalid_q;
    assign ar_idx_c = S_AXI_ARADDR[C_AXI_ADDR_WIDTH-1:ADDR_LSB];

    // Write-side decode; indices beyond N match no word and become SLVERR
    always_comb begin
        wr_hit_c = '0;
        wr_old_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (aw_idx_q == IDX_W'(i)) begin
                wr_hit_c[i] = 1'b1;
                wr_old_c    = regs_q[i];
            end
        end
        wr_en_c = wr_hit_c & ~C_RO_MASK;
        wr_ok_c = |wr_en_c;
    end

    always_comb begin
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        if (commit_c) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end else begin
            if (aw_hs_c) aw_held_d = 1'b1;
            if (w_hs_c)  w_held_d  = 1'b1;
        end
    end

    axi_4_lite_strb_merge #(
        .DATA_W (DATA_W)
    ) u_strb_merge (
        .old_data (wr_old_c),
        .new_data (w_data_q),
        .strb     (w_strb_q),
        .merged_c (wr_merged_c)
    );

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awready_q  <= 1'b1;
            wready_q   <= 1'b1;
            aw_idx_q   <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
        end else begin
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            awready_q  <= !aw_held_d;
            wready_q   <= !w_held_d;
            wr_pulse_q <= '0;
            if (aw_hs_c) aw_idx_q <= S_AXI_AWADDR[C_AXI_ADDR_WIDTH-1:ADDR_LSB];
            if (w_hs_c) begin
                w_data_q <= S_AXI_WDATA;
                w_strb_q <= S_AXI_WSTRB;
            end
            if (commit_c) begin
                bvalid_q   <= 1'b1;
                bresp_q    <= resp_of(wr_ok_c);
                wr_pulse_q <= wr_en_c;
            end else if (bvalid_q && S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int unsigned i = 0; i < N; i++) regs_q[i] <= '0;
        end else if (commit_c) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (wr_en_c[i]) regs_q[i] <= wr_merged_c;
            end
        end
    end

    // Read source: read-only words come from RO_IN, others from storage
    always_comb begin
        rd_ok_c   = 1'b0;
        rd_data_c = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (ar_idx_c == IDX_W'(i)) begin
                rd_ok_c   = 1'b1;
                rd_data_c = C_RO_MASK[i] ? RO_IN[i*DATA_W +: DATA_W] : regs_q[i];
            end
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        if (ar_hs_c)                        rvalid_d = 1'b1;
        else if (rvalid_q && S_AXI_RREADY)  rvalid_d = 1'b0;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            rvalid_q  <= rvalid_d;
            arready_q <= !rvalid_d;
            if (ar_hs_c) begin
                rdata_q <= rd_data_c;
                rresp_q <= resp_of(rd_ok_c);
            end
        end
    end

    assign S_AXI_AWREADY = awready_q;
    assign S_AXI_WREADY  = wready_q;
    assign S_AXI_BVALID  = bvalid_q;
    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign WR_PULSE      = wr_pulse_q;

    for (genvar g = 0; g < N; g++) begin : g_reg_out
        assign REG_OUT[g*DATA_W +: DATA_W] = regs_q[g];
    end

    // Protection bits and sub-word address bits carry no meaning here
    logic unused_ok;
    assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                         S_AXI_AWADDR[ADDR_LSB-1:0], S_AXI_ARADDR[ADDR_LSB-1:0], RO_IN};

endmodule
